mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the 128-bit line interface driven by the L1 caches (mem_read/mem_write/mem_addr/mem_wdata -> mem_rdata/mem_ready).
// - Provides a synthesizable backing store with programmable fixed latency, so cache RTL can be simulated and synthesized against a realistic slow memory.
// - Sits below the I/D caches; one responder per cache port.
// PARAMETERS
// - LATENCY     4   cycles from accept cycle to the mem_ready cycle; legal range 1..15
// - DEPTH_LOG2  8   log2 of line count in backing array; index = mem_addr[DEPTH_LOG2-1:0]
// - CNT_W       16  width of saturating transaction counters
// PORTS
// - clk         in   1           clock, all logic on posedge
// - proc_reset  in   1           synchronous active-high reset
// - mem_read    in   1           line read request, held high until mem_ready seen
// - mem_write   in   1           line write request, held high until mem_ready seen
// - mem_addr    in   28          line address (byte addr >> 4)
// - mem_wdata   in   128         write line data
// - mem_rdata   out  128         read line data, valid only while mem_ready=1
// - mem_ready   out  1           one-cycle completion pulse
// - rd_cnt      out  CNT_W       completed reads, saturating
// - wr_cnt      out  CNT_W       completed writes, saturating
// BEHAVIOUR
// - Reset: mem_ready=0, mem_rdata=0, rd_cnt=wr_cnt=0, state=IDLE, line-valid bitmap all 0. Array data not cleared.
// - All outputs registered.
// - FSM IDLE -> BUSY -> RESP -> DONE -> IDLE.
// - IDLE: if mem_write|mem_read, accept.
//   - Latch mem_addr index, mem_wdata, op (write wins when both are high; read stays pending and is accepted after DONE).
//   - Load counter with LATENCY-1; go to BUSY (RESP directly when LATENCY=1).
// - BUSY: decrement counter each cycle; at 0 -> RESP. Inputs ignored; addr/data changes after accept have no effect.
// - RESP (exactly 1 cycle): mem_ready=1 for all ops.
//   - Read: mem_rdata = array[idx] if valid[idx], else 128'h0.
//   - Write: array[idx] <= latched wdata and valid[idx] <= 1 at the RESP edge; mem_rdata = 0.
//   - Counter of the completed op increments, holding at all-ones.
// - DONE (1 cycle): mem_ready=0, mem_rdata=0, requests ignored (the cache's registered request drops here) -> IDLE.
// - Timing: accept in cycle T; mem_ready high in cycle T+LATENCY. Minimum request-to-request spacing is LATENCY+2 cycles.
// - Request dropped before RESP: transaction still completes, ready still pulses, write still commits.
// - Address aliasing: mem_addr bits above DEPTH_LOG2 ignored; lines alias modulo 2^DEPTH_LOG2.
// - Read-after-write same line: the read accepted after DONE returns the new data.
// - Reset mid-transaction: abort immediately; uncommitted write lost; no ready pulse; next cycle IDLE with reset values.
// - Reset has priority over every other event in the same cycle.
// TESTING
// - Reset, then read addr 28'h0000005, LATENCY=4 -> mem_ready high exactly 4 cycles after accept, 1 cycle wide, mem_rdata=128'h0, rd_cnt=1.
// - Write addr 28'h0000012 data 128'hDEADBEEF_..._0123, then read same addr -> ready pulse each op, read returns written line, wr_cnt=1, rd_cnt=1.
// - Write addr 28'h0000112 (aliases 28'h12 when DEPTH_LOG2=8), then read 28'h0000012 -> returns the aliased write data.
// - mem_read and mem_write both high at accept -> write serviced first, then read accepted after DONE returns the new data; two ready pulses.
// - Assert proc_reset in BUSY of a write to 28'h3 -> no mem_ready; read 28'h3 afterwards returns 128'h0 (valid bit cleared).
// - Drive the cache_i read-miss sequence with LATENCY=1 and 15 -> cache fills correctly; no double accept; mem_read low in the DONE cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the 128-bit L1 line interface.
// The backing store is synthesizable, and a valid bitmap makes never-written lines read as zero.
module mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [27:0]       mem_addr,
  input  logic [127:0]      mem_wdata,
  output logic [127:0]      mem_rdata,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned LAT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LAT_W-1:0]        cnt_q, cnt_d;
  logic                    accept_c;
  logic                    enter_resp_c;

  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    wr_q;
  logic [DATA_W-1:0]       wdata_q;

  logic [DEPTH_LOG2-1:0]   idx_c;
  logic                    op_wr_c;
  logic [DATA_W-1:0]       wdata_c;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;

  logic                    unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  // State register
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; enter_resp_c marks the edge that raises mem_ready and commits the op
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_c     = 1'b0;
    enter_resp_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          accept_c = 1'b1;
          cnt_d    = LAT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Live inputs are used on the accept edge itself so that LATENCY=1 works
  always_comb begin
    idx_c   = accept_c ? mem_addr[DEPTH_LOG2-1:0] : idx_q;
    op_wr_c = accept_c ? mem_write : wr_q;
    wdata_c = accept_c ? mem_wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      idx_q   <= mem_addr[DEPTH_LOG2-1:0];
      wr_q    <= mem_write;
      wdata_q <= mem_wdata;
    end
  end

  // Backing array, never cleared; the valid bitmap masks stale contents
  always_ff @(posedge clk) begin
    if (!proc_reset && enter_resp_c && op_wr_c) begin
      mem_q[idx_c] <= wdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      valid_q   <= '0;
    end else begin
      mem_ready <= enter_resp_c;
      mem_rdata <= (enter_resp_c && !op_wr_c && valid_q[idx_c]) ? mem_q[idx_c] : '0;
      if (enter_resp_c) begin
        if (op_wr_c) begin
          valid_q[idx_c] <= 1'b1;
          if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
        end else begin
          if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
